twd_seq_ctrl: RTL
=================

TWD_SEQ_CTRL -- requirements
Module: twd_seq_ctrl

Interface
REQ-001 SHALL have parameter CLK_CNT, default 16, meaning cycles per frame block (power of two, >=4).
REQ-002 SHALL have parameter BFLY_LAT, default 1, meaning cycles from input sample to butterfly output at twiddle-stage input (>=1).
REQ-003 SHALL have parameter TWD_LAT, default 1, meaning cycles from twiddle-stage input to stage output (>=1).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clr  input  1  synchronous soft clear.
REQ-007 SHALL have port din_valid  input  1  upstream sample valid, one lane-group per cycle.
REQ-008 SHALL have port bfly_en  output  1  butterfly enable, equal to din_valid while RUN.
REQ-009 SHALL have port twd_valid  output  1  twiddle-stage enable (drives twiddle counter en).
REQ-010 SHALL have port twd_cnt  output  $clog2(CLK_CNT)  sample index aligned with twd_valid.
REQ-011 SHALL have port twd_idx  output  2  quadrant = twd_cnt / (CLK_CNT/4).
REQ-012 SHALL have port rot_en  output  1  -j rotation select, twd_valid and twd_idx==3.
REQ-013 SHALL have port dout_valid  output  1  stage output valid.
REQ-014 SHALL have ports frame_start, frame_done, err_gap  output  1 each  single-cycle pulses.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 IDLE: din_valid=1 SHALL move to RUN, count the sample as index 0, pulse frame_start that cycle.
REQ-018 RUN: each din_valid=1 cycle SHALL increment in-frame counter, wrapping CLK_CNT-1 -> 0.
REQ-019 Sample with index 0 accepted while RUN SHALL pulse frame_start (back-to-back frames stay in RUN, no bubble).
REQ-020 din_valid=0 mid-frame (counter not at 0) SHALL pulse err_gap once per gap, hold counter, suppress bfly_en, resume on next valid.
REQ-021 din_valid=0 at frame boundary (counter at 0 after wrap) SHALL move RUN -> DRAIN.
REQ-022 DRAIN: SHALL wait BFLY_LAT+TWD_LAT cycles then enter IDLE; din_valid=1 in DRAIN SHALL enter RUN as in REQ-017 while in-flight outputs continue.
REQ-023 twd_valid and twd_cnt SHALL equal bfly_en and in-frame index delayed exactly BFLY_LAT cycles.
REQ-024 dout_valid SHALL equal twd_valid delayed exactly TWD_LAT cycles.
REQ-025 frame_done SHALL pulse in the same cycle as dout_valid of each index CLK_CNT-1 sample.
REQ-026 twd_idx and rot_en SHALL be combinational from registered twd_cnt/twd_valid; twd_idx SHALL be 0 when twd_valid=0.
REQ-027 Delayed valids SHALL be independent of FSM state so gaps propagate as gaps in twd_valid/dout_valid.
REQ-028 clr=1 SHALL override all other inputs that cycle: state IDLE, counter 0, delay lines flushed, pulses not generated.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE, counter 0, all delay stages 0, every output 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; first valid after release SHALL start as index 0 with frame_start.

Structure
REQ-031 Package fft_ctrl_pkg SHALL hold the FSM state enum and default CLK_CNT/latency constants.
REQ-032 A sub-module valid_delay (parameter DEPTH, WIDTH; async-reset shift register with sync clear) SHALL implement the BFLY_LAT and TWD_LAT alignment lines.
REQ-033 Counter SHALL be local to this block; no multipliers or datapath in this block.

Verification (defaults CLK_CNT=16, BFLY_LAT=1, TWD_LAT=1)
REQ-034 16 consecutive valids from IDLE -> frame_start at cycle 0, twd_valid cycles 1-16, rot_en cycles 13-16, dout_valid cycles 2-17, frame_done cycle 17, busy low cycle 19.
REQ-035 32 consecutive valids -> two frame_start pulses 16 cycles apart, no DRAIN, twd_cnt wraps 15 -> 0 without gap.
REQ-036 valid low 3 cycles after index 5 -> one err_gap pulse, counter holds 5, index 6 on resume, 3-cycle hole in twd_valid and dout_valid.
REQ-037 rstn low after index 9 then 16 valids -> all outputs 0 during reset, new frame_start, twd_cnt restarts 0, single frame_done.
REQ-038 clr in cycle 1 of DRAIN -> no frame_done, dout_valid 0 next cycle, state IDLE.
REQ-039 New valid in DRAIN cycle 1 -> frame_start pulse, previous frame_done still emitted on time, busy stays high.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg
// Shared definitions for the twiddle-stage sequencing controller: the FSM
// state encoding and the default frame size and pipeline latencies.
package fft_ctrl_pkg;

  // IDLE: no frame in progress; RUN: accepting samples of a frame;
  // DRAIN: frame complete, waiting for the pipeline to empty.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_CLK_CNT  = 16;
  localparam int DEF_BFLY_LAT = 1;
  localparam int DEF_TWD_LAT  = 1;

endpackage

// File: rtl/valid_delay.sv
// valid_delay
// Fixed-depth shift register used to align valid flags and sideband bits
// with the datapath pipeline. All stages reset to zero.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset, clears every stage
//   clr   - synchronous clear, flushes every stage on the next edge
//   din   - value entering the line
//   dout  - value delayed by exactly DEPTH cycles
module valid_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = clr ? '0 : din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = clr ? '0 : stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/twd_seq_ctrl.sv
// twd_seq_ctrl
// Sequencing controller for an FFT twiddle stage. Tracks the in-frame sample
// index, generates the butterfly enable, and carries valid/index alongside
// the butterfly and twiddle pipelines so the twiddle stage sees a sample
// index aligned with its data.
// Ports:
//   clk, rstn    - clock (rising edge), asynchronous active-low reset
//   clr          - synchronous soft clear, overrides everything else
//   din_valid    - upstream sample valid
//   bfly_en      - butterfly enable for the accepted sample
//   twd_valid    - twiddle-stage enable, bfly_en delayed BFLY_LAT cycles
//   twd_cnt      - sample index aligned with twd_valid
//   twd_idx      - quadrant of twd_cnt (0 when twd_valid is low)
//   rot_en       - -j rotation select (quadrant 3)
//   dout_valid   - stage output valid, twd_valid delayed TWD_LAT cycles
//   frame_start  - pulse on acceptance of an index-0 sample
//   frame_done   - pulse with dout_valid of the last sample of a frame
//   err_gap      - pulse on the first idle cycle of a mid-frame gap
//   busy         - high whenever the FSM is not IDLE
module twd_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int CLK_CNT  = DEF_CLK_CNT,
  parameter int BFLY_LAT = DEF_BFLY_LAT,
  parameter int TWD_LAT  = DEF_TWD_LAT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       din_valid,
  output logic                       bfly_en,
  output logic                       twd_valid,
  output logic [$clog2(CLK_CNT)-1:0] twd_cnt,
  output logic [1:0]                 twd_idx,
  output logic                       rot_en,
  output logic                       dout_valid,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       err_gap,
  output logic                       busy
);

  localparam int CW        = $clog2(CLK_CNT);
  localparam int DRAIN_LAT = BFLY_LAT + TWD_LAT;
  localparam int DW        = $clog2(DRAIN_LAT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gap_q, gap_d;
  logic [DW-1:0]   drain_q, drain_d;

  logic            accept;
  logic [CW-1:0]   cur_idx;
  logic            dout_last;

  // A sample arriving outside RUN always opens a new frame, so its index is 0;
  // inside RUN the counter already holds the index of the next sample.
  // Gating with rstn keeps the combinational outputs quiet during reset.
  always_comb begin
    accept      = din_valid && !clr && rstn;
    cur_idx     = (state_q == ST_RUN) ? cnt_q : '0;
    bfly_en     = accept;
    frame_start = accept && (cur_idx == '0);
    err_gap     = !clr && (state_q == ST_RUN) && !din_valid &&
                  (cnt_q != '0) && !gap_q;
  end

  // Next-state logic. The counter is a power of two wide, so the natural
  // overflow of the increment implements the CLK_CNT-1 -> 0 wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    drain_d = drain_q;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      gap_d   = 1'b0;
      drain_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (din_valid) begin
            state_d = ST_RUN;
            cnt_d   = CW'(1);
          end
        end
        ST_RUN: begin
          if (din_valid) begin
            cnt_d = cnt_q + 1'b1;
            gap_d = 1'b0;
          end else if (cnt_q == '0) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            gap_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (din_valid) begin
            state_d = ST_RUN;
            cnt_d   = CW'(1);
            drain_d = '0;
          end else if (drain_q == DW'(DRAIN_LAT - 1)) begin
            state_d = ST_IDLE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gap_d   = 1'b0;
          drain_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
    end
  end

  // Index is zeroed for idle slots so twd_cnt only carries meaning with twd_valid.
  valid_delay #(
    .DEPTH (BFLY_LAT),
    .WIDTH (CW + 1)
  ) u_bfly_dly (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .din  ({accept, accept ? cur_idx : {CW{1'b0}}}),
    .dout ({twd_valid, twd_cnt})
  );

  // Only a last-sample flag needs to follow the twiddle stage for frame_done.
  valid_delay #(
    .DEPTH (TWD_LAT),
    .WIDTH (2)
  ) u_twd_dly (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .din  ({twd_valid, twd_valid && (twd_cnt == CW'(CLK_CNT - 1))}),
    .dout ({dout_valid, dout_last})
  );

  always_comb begin
    twd_idx    = twd_valid ? twd_cnt[CW-1 -: 2] : 2'b00;
    rot_en     = twd_valid && (twd_idx == 2'b11);
    frame_done = dout_valid && dout_last && !clr;
    busy       = (state_q != ST_IDLE);
  end

endmodule
